// File: rtl/riscv_load_store_unit.sv
// Load/store stage: one word-aligned access per LOAD/STORE over req/ready.
// Optional watchdog on mem_ready enabled by LSU_TIMEOUT_EN.
module riscv_load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, ACCESS, FIN} state_t;

  state_t      state;
  logic        ld_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        accept;
  logic        legal;
  logic        mis;
  logic [3:0]  mask_n;
  logic [31:0] wdata_n;

  function automatic logic [31:0] extract(
    input logic [2:0]  f,
    input logic [1:0]  o,
    input logic [31:0] w
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{o, 3'b000} +: 8];
    h = o[1] ? w[31:16] : w[15:0];
    case (f)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  assign accept = start && (state == IDLE) && (is_load ^ is_store);

  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = is_load;
      default:                legal = 1'b0;
    endcase
  end

  assign mis = ((funct3[1:0] == 2'b01) && addr[0]) ||
               ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

  always_comb begin
    mask_n  = 4'b0000;
    wdata_n = 32'd0;
    if (is_store) begin
      unique case (1'b1)
        (funct3[1:0] == 2'b00): begin
          mask_n  = 4'b0001 << addr[1:0];
          wdata_n = {4{store_data[7:0]}};
        end
        (funct3[1:0] == 2'b01): begin
          mask_n  = 4'b0011 << {addr[1], 1'b0};
          wdata_n = {2{store_data[15:0]}};
        end
        default: begin
          mask_n  = 4'b1111;
          wdata_n = store_data;
        end
      endcase
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt;
`endif

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      load_data <= 32'd0;
      fault     <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wmask <= 4'b0000;
      mem_wdata <= 32'd0;
      ld_q      <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
`ifdef LSU_TIMEOUT_EN
      cnt       <= 16'd0;
      timeout   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            busy  <= 1'b1;
            fault <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            timeout <= 1'b0;
            cnt     <= 16'd0;
`endif
            if (!legal || mis) begin
              state     <= FIN;
              done      <= 1'b1;
              fault     <= 1'b1;
              load_data <= 32'd0;
            end else begin
              state     <= ACCESS;
              mem_req   <= 1'b1;
              ld_q      <= is_load;
              f3_q      <= funct3;
              off_q     <= addr[1:0];
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wmask <= mask_n;
              mem_wdata <= wdata_n;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            state     <= FIN;
            mem_req   <= 1'b0;
            done      <= 1'b1;
            load_data <= ld_q ? extract(f3_q, off_q, mem_rdata) : 32'd0;
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt + 16'd1 == TMO) begin
            state     <= FIN;
            mem_req   <= 1'b0;
            done      <= 1'b1;
            fault     <= 1'b1;
            timeout   <= 1'b1;
            load_data <= 32'd0;
          end else begin
            cnt <= cnt + 16'd1;
          end
`endif
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef LSU_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_load_store_unit.sv
// Directed bench for riscv_load_store_unit with a result scoreboard.
// Timeout scenario runs only when LSU_TIMEOUT_EN is defined.
module tb_riscv_load_store_unit;

  logic        clk = 1'b0;
  logic        RESET;
  logic        start;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        fault;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        timeout;

  typedef struct {
    string       tag;
    logic [31:0] ld;
    logic        flt;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  riscv_load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .RESET      (RESET),
    .start      (start),
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .fault      (fault),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wmask  (mem_wmask),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask

  task automatic pop_check(input string t);
    exp_t e;
    n_chk++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL %s scoreboard observed=empty expected=entry", t);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, " load_data"}, load_data, e.ld);
    chk({e.tag, " fault"}, {31'd0, fault}, {31'd0, e.flt});
    chk({e.tag, " timeout"}, {31'd0, timeout}, {31'd0, e.tmo});
  endtask

  task automatic drive_start(input bit ld, input bit st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    start = 1'b1; is_load = ld; is_store = st;
    funct3 = f3; addr = a; store_data = d;
    @(negedge clk);
    start = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask

  task automatic run(input string tag, input bit ld, input bit st,
                     input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] rd,
                     input int waits, input bit mid_start,
                     input logic [31:0] exp_ld, input bit exp_flt,
                     input logic [3:0] exp_mask, input logic [31:0] exp_wd);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    sb.push_back('{tag, exp_ld, exp_flt, 1'b0});
    mem_rdata = rd;
    drive_start(ld, st, f3, a, d);
    if (exp_flt) begin
      chk({tag, " mem_req"}, {31'd0, mem_req}, 32'd0);
    end else begin
      chk({tag, " mem_req"}, {31'd0, mem_req}, 32'd1);
      chk({tag, " mem_addr"}, mem_addr, wa);
      chk({tag, " wmask"}, {28'd0, mem_wmask}, {28'd0, exp_mask});
      chk({tag, " wdata"}, mem_wdata, exp_wd);
      for (int i = 0; i < waits; i++) begin
        if (mid_start && i == 1) begin
          start = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h200;
        end
        @(negedge clk);
        start = 1'b0; is_load = 1'b0;
        chk({tag, " wait req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, " wait addr"}, mem_addr, wa);
        chk({tag, " wait wmask"}, {28'd0, mem_wmask}, {28'd0, exp_mask});
        chk({tag, " wait wdata"}, mem_wdata, exp_wd);
        chk({tag, " wait done"}, {31'd0, done}, 32'd0);
      end
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
    end
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " busy"}, {31'd0, busy}, 32'd1);
    pop_check(tag);
    @(negedge clk);
    chk({tag, " done end"}, {31'd0, done}, 32'd0);
    chk({tag, " busy end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    RESET = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = 3'b000; addr = 32'd0; store_data = 32'd0;
    mem_rdata = 32'd0; mem_ready = 1'b0;
    #1;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst req", {31'd0, mem_req}, 32'd0);
    chk("rst wmask", {28'd0, mem_wmask}, 32'd0);
    chk("rst timeout", {31'd0, timeout}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    RESET = 1'b0;

    run("sw", 0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 32'd0, 0, 0,
        32'd0, 0, 4'b1111, 32'hDEADBEEF);
    run("sb", 0, 1, 3'b000, 32'h103, 32'h000000A5, 32'd0, 0, 0,
        32'd0, 0, 4'b1000, 32'hA5A5A5A5);
    run("sh", 0, 1, 3'b001, 32'h102, 32'h00001234, 32'd0, 0, 0,
        32'd0, 0, 4'b1100, 32'h12341234);
    run("lb", 1, 0, 3'b000, 32'h0, 32'd0, 32'h80F07F81, 0, 0,
        32'hFFFFFF81, 0, 4'b0000, 32'd0);
    run("lbu", 1, 0, 3'b100, 32'h0, 32'd0, 32'h80F07F81, 0, 0,
        32'h00000081, 0, 4'b0000, 32'd0);
    run("lh", 1, 0, 3'b001, 32'h2, 32'd0, 32'h80F07F81, 0, 0,
        32'hFFFF80F0, 0, 4'b0000, 32'd0);
    run("lhu", 1, 0, 3'b101, 32'h2, 32'd0, 32'h80F07F81, 0, 0,
        32'h000080F0, 0, 4'b0000, 32'd0);
    run("lw", 1, 0, 3'b010, 32'h0, 32'd0, 32'h80F07F81, 0, 0,
        32'h80F07F81, 0, 4'b0000, 32'd0);
    run("lb3", 1, 0, 3'b000, 32'h3, 32'd0, 32'h80F07F81, 0, 0,
        32'hFFFFFF80, 0, 4'b0000, 32'd0);
    run("lw mis", 1, 0, 3'b010, 32'h102, 32'd0, 32'd0, 0, 0,
        32'd0, 1, 4'b0000, 32'd0);
    run("lh mis", 1, 0, 3'b001, 32'h101, 32'd0, 32'd0, 0, 0,
        32'd0, 1, 4'b0000, 32'd0);
    run("lw ok", 1, 0, 3'b010, 32'h10, 32'd0, 32'h0BADF00D, 0, 0,
        32'h0BADF00D, 0, 4'b0000, 32'd0);
    run("ld f3", 1, 0, 3'b011, 32'h0, 32'd0, 32'd0, 0, 0,
        32'd0, 1, 4'b0000, 32'd0);
    run("sbu f3", 0, 1, 3'b100, 32'h0, 32'd0, 32'd0, 0, 0,
        32'd0, 1, 4'b0000, 32'd0);
    run("wait", 1, 0, 3'b010, 32'h40, 32'd0, 32'h11223344, 5, 1,
        32'h11223344, 0, 4'b0000, 32'd0);

    // both flags set: ignored
    drive_start(1, 1, 3'b010, 32'h0, 32'd0);
    chk("ign busy", {31'd0, busy}, 32'd0);
    chk("ign req", {31'd0, mem_req}, 32'd0);
    chk("ign done", {31'd0, done}, 32'd0);

`ifdef LSU_TIMEOUT_EN
    sb.push_back('{"tmo", 32'd0, 1'b1, 1'b1});
    drive_start(0, 1, 3'b010, 32'h8, 32'h55);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("tmo req", {31'd0, mem_req}, 32'd1);
      chk("tmo done early", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    chk("tmo done", {31'd0, done}, 32'd1);
    chk("tmo req off", {31'd0, mem_req}, 32'd0);
    pop_check("tmo");
    @(negedge clk);
    chk("tmo held", {31'd0, timeout}, 32'd1);
`else
    chk("timeout tied", {31'd0, timeout}, 32'd0);
`endif

    mem_rdata = 32'hCAFEBABE;
    drive_start(1, 0, 3'b010, 32'h44, 32'd0);
    chk("pre-rst req", {31'd0, mem_req}, 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk("midrst req", {31'd0, mem_req}, 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst addr", mem_addr, 32'd0);
    chk("midrst ld", load_data, 32'd0);
    @(negedge clk);
    RESET = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("post-rst done", {31'd0, done}, 32'd0);
    chk("post-rst busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
